cal_day_counter: RTL and testbench

//  Day-of-year tracker feeding the calendar ROM (365 x 12-bit, 9-bit address).

---
 rtl/cal_pkg.sv | 16 +
 rtl/mod_n_updown.sv | 36 +++
 rtl/cal_day_counter.sv | 86 ++++++++
 tb/tb_cal_day_counter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cal_pkg.sv
// cal_pkg: shared constants, ROM word field slices and FSM state encoding
//   DAYS_C / ADDR_W_C / DATA_W_C : calendar ROM geometry
//   MON_* / DAY_* / WD_*         : bit positions of the fields in a ROM word
//   state_t                      : RUN follows the midnight tick, SET follows buttons
package cal_pkg;
    localparam int DAYS_C   = 365;
    localparam int ADDR_W_C = 9;
    localparam int DATA_W_C = 12;
    localparam int MON_HI   = 11;
    localparam int MON_LO   = 8;
    localparam int DAY_HI   = 7;
    localparam int DAY_LO   = 3;
    localparam int WD_HI    = 2;
    localparam int WD_LO    = 0;
    typedef enum logic {RUN = 1'b0, SET = 1'b1} state_t;
endpackage

// File: rtl/mod_n_updown.sv
// mod_n_updown: modulo-N up/down counter with a wrap-forward flag
//   clk, reset : clock and synchronous active-high reset (count -> 0)
//   up, down   : step requests; both together cancel
//   count      : registered value, always within 0..N-1
//   wrap       : combinational, high when this cycle's step goes N-1 -> 0
module mod_n_updown
    import cal_pkg::*;
#(
    parameter int N = DAYS_C,
    parameter int W = ADDR_W_C
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         up,
    input  logic         down,
    output logic [W-1:0] count,
    output logic         wrap
);
    localparam logic [W-1:0] MAX = W'(N - 1);

    logic at_max;
    logic at_min;

    assign at_max = (count == MAX);
    assign at_min = (count == '0);
    assign wrap   = up && !down && at_max;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (up && !down)
            count <= at_max ? '0 : count + 1'b1;
        else if (down && !up)
            count <= at_min ? MAX : count - 1'b1;
    end
endmodule

// File: rtl/cal_day_counter.sv
// cal_day_counter: day-of-year index driving the calendar ROM, with registered date fields
//   clk, reset          : clock, synchronous active-high reset
//   day_tick            : midnight pulse, advances the day in RUN
//   set_mode            : level, selects SET (buttons) vs RUN (tick)
//   btn_up, btn_down    : single-cycle step pulses used in SET
//   rom_address         : registered day index 0..DAYS-1
//   rom_data            : combinational ROM word for rom_address
//   month, day, weekday : registered ROM word fields
//   date_valid          : fields match the current rom_address
//   year_wrap           : one-cycle pulse when the tick wraps the last day to 0
module cal_day_counter
    import cal_pkg::*;
#(
    parameter int DAYS   = DAYS_C,
    parameter int ADDR_W = ADDR_W_C,
    parameter int DATA_W = DATA_W_C
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              day_tick,
    input  logic              set_mode,
    input  logic              btn_up,
    input  logic              btn_down,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data,
    output logic [3:0]        month,
    output logic [4:0]        day,
    output logic [2:0]        weekday,
    output logic              date_valid,
    output logic              year_wrap
);
    state_t state;
    state_t state_next;
    logic   up;
    logic   down;
    logic   wrap;
    logic   step;
    logic   after_reset;

    always_ff @(posedge clk) begin
        if (reset)
            state <= RUN;
        else
            state <= state_next;
    end

    // Pulses are routed by the current (old) state, so a pulse coinciding
    // with a mode change is handled under the mode being left.
    always_comb begin
        state_next = set_mode ? SET : RUN;
        up         = (state == RUN) ? day_tick : btn_up;
        down       = (state == SET) && btn_down;
    end

    assign step = up ^ down;

    mod_n_updown #(.N(DAYS), .W(ADDR_W)) u_counter (
        .clk   (clk),
        .reset (reset),
        .up    (up),
        .down  (down),
        .count (rom_address),
        .wrap  (wrap)
    );

    // A step moves rom_address this edge, so the fields captured now belong to
    // the old index: flag invalid for one cycle. The first edge after reset
    // still holds zeroed fields, so it is treated the same way.
    always_ff @(posedge clk) begin
        if (reset) begin
            month       <= '0;
            day         <= '0;
            weekday     <= '0;
            date_valid  <= 1'b0;
            year_wrap   <= 1'b0;
            after_reset <= 1'b1;
        end else begin
            month       <= rom_data[MON_HI:MON_LO];
            day         <= rom_data[DAY_HI:DAY_LO];
            weekday     <= rom_data[WD_HI:WD_LO];
            date_valid  <= !step && !after_reset;
            year_wrap   <= (state == RUN) && wrap;
            after_reset <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cal_day_counter.sv
// tb_cal_day_counter: self-checking bench with a calendar ROM model and a date-level reference model
module tb_cal_day_counter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        day_tick = 1'b0;
    logic        set_mode = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic [8:0]  rom_address;
    logic [11:0] rom_data;
    logic [3:0]  month;
    logic [4:0]  day;
    logic [2:0]  weekday;
    logic        date_valid;
    logic        year_wrap;

    int          passed = 0;
    int          total = 0;
    int          e_addr = 0;
    logic        e_set = 1'b0;
    logic [11:0] e_fields = '0;
    logic        e_valid = 1'b0;
    logic        e_wrap = 1'b0;
    logic        e_after_rst = 1'b1;

    always #5 clk = ~clk;

    // Calendar for a non-leap year starting on weekday 1
    function automatic logic [11:0] date_of(input int idx);
        int mlen[12];
        int m;
        int d;
        mlen = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        m = 0;
        d = idx;
        while (m < 11 && d >= mlen[m]) begin
            d -= mlen[m];
            m++;
        end
        return {4'(m + 1), 5'(d + 1), 3'((idx + 1) % 7)};
    endfunction

    assign rom_data = (rom_address < 9'd365) ? date_of(int'(rom_address)) : 12'h000;

    cal_day_counter dut (
        .clk         (clk),
        .reset       (reset),
        .day_tick    (day_tick),
        .set_mode    (set_mode),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .rom_address (rom_address),
        .rom_data    (rom_data),
        .month       (month),
        .day         (day),
        .weekday     (weekday),
        .date_valid  (date_valid),
        .year_wrap   (year_wrap)
    );

    // Drive one cycle of inputs, clock once, and advance the reference model
    task automatic do_cycle(input logic r, input logic t, input logic s, input logic u, input logic d);
        int prev;
        int delta;
        reset = r; day_tick = t; set_mode = s; btn_up = u; btn_down = d;
        @(posedge clk);
        #1;
        prev = e_addr;
        if (r) begin
            e_addr = 0; e_set = 1'b0; e_fields = '0; e_valid = 1'b0; e_wrap = 1'b0; e_after_rst = 1'b1;
        end else begin
            delta = !e_set ? int'(t) : (u && !d) ? 1 : (d && !u) ? -1 : 0;
            e_addr = (prev + delta + 365) % 365;
            e_wrap = !e_set && t && prev == 364;
            e_fields = date_of(prev);
            e_valid = (delta == 0) && !e_after_rst;
            e_after_rst = 1'b0;
            e_set = s;
        end
        day_tick = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) do_cycle(1, 0, 0, 0, 0);
        total++; if (rom_address !== 9'd0) $display("FAIL reset_addr: got %0d want 0", rom_address); else passed++;
        total++; if (date_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", date_valid); else passed++;
        total++; if ({month, day, weekday} !== 12'h000) $display("FAIL reset_fields: got %h want 000", {month, day, weekday}); else passed++;
        total++; if (year_wrap !== 1'b0) $display("FAIL reset_wrap: got %b want 0", year_wrap); else passed++;
        do_cycle(0, 0, 0, 0, 0);
        total++; if (date_valid !== 1'b0) $display("FAIL valid_edge1: got %b want 0", date_valid); else passed++;
        do_cycle(0, 0, 0, 0, 0);
        total++; if (date_valid !== 1'b1) $display("FAIL valid_edge2: got %b want 1", date_valid); else passed++;
        total++; if (month !== 4'd1 || day !== 5'd1 || weekday !== 3'd1)
            $display("FAIL jan1_fields: got %0d/%0d wd%0d want 1/1 wd1", month, day, weekday); else passed++;
    endtask

    task automatic test_run_ticks();
        do_cycle(1, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0);
        repeat (31) do_cycle(0, 1, 0, 0, 0);
        total++; if (rom_address !== 9'd31) $display("FAIL ticks_addr: got %0d want 31", rom_address); else passed++;
        total++; if (date_valid !== 1'b0) $display("FAIL ticks_valid: got %b want 0", date_valid); else passed++;
        do_cycle(0, 0, 0, 0, 0);
        total++; if (month !== 4'd2 || day !== 5'd1) $display("FAIL feb1_fields: got %0d/%0d want 2/1", month, day); else passed++;
        total++; if ({month, day, weekday} !== e_fields) $display("FAIL feb1_word: got %h want %h", {month, day, weekday}, e_fields); else passed++;
        total++; if (date_valid !== 1'b1) $display("FAIL feb1_valid: got %b want 1", date_valid); else passed++;
    endtask

    task automatic test_year_wrap();
        do_cycle(1, 0, 0, 0, 0);
        do_cycle(0, 0, 1, 0, 0);
        do_cycle(0, 0, 1, 0, 1);
        do_cycle(0, 0, 0, 0, 0);
        total++; if (rom_address !== 9'd364) $display("FAIL pre_wrap_addr: got %0d want 364", rom_address); else passed++;
        do_cycle(0, 1, 0, 0, 0);
        total++; if (rom_address !== 9'd0) $display("FAIL wrap_addr: got %0d want 0", rom_address); else passed++;
        total++; if (year_wrap !== 1'b1) $display("FAIL wrap_pulse: got %b want 1", year_wrap); else passed++;
        do_cycle(0, 0, 0, 0, 0);
        total++; if (year_wrap !== 1'b0) $display("FAIL wrap_width: got %b want 0", year_wrap); else passed++;
        total++; if (month !== 4'd1 || day !== 5'd1) $display("FAIL wrap_fields: got %0d/%0d want 1/1", month, day); else passed++;
    endtask

    task automatic test_set();
        do_cycle(1, 0, 0, 0, 0);
        do_cycle(0, 0, 1, 0, 0);
        do_cycle(0, 0, 1, 0, 1);
        total++; if (rom_address !== 9'd364) $display("FAIL set_down_wrap: got %0d want 364", rom_address); else passed++;
        do_cycle(0, 0, 1, 1, 0);
        total++; if (rom_address !== 9'd0) $display("FAIL set_up_wrap: got %0d want 0", rom_address); else passed++;
        total++; if (year_wrap !== 1'b0) $display("FAIL set_up_no_wrap: got %b want 0", year_wrap); else passed++;
        do_cycle(0, 0, 1, 1, 1);
        total++; if (rom_address !== 9'd0) $display("FAIL set_both: got %0d want 0", rom_address); else passed++;
        do_cycle(0, 1, 1, 0, 0);
        total++; if (rom_address !== 9'd0) $display("FAIL set_tick_drop: got %0d want 0", rom_address); else passed++;
        total++; if (year_wrap !== 1'b0) $display("FAIL set_tick_wrap: got %b want 0", year_wrap); else passed++;
        total++; if (date_valid !== e_valid) $display("FAIL set_valid: got %b want %b", date_valid, e_valid); else passed++;
    endtask

    task automatic test_mode_edge();
        do_cycle(1, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0);
        do_cycle(0, 1, 1, 0, 0);
        total++; if (rom_address !== 9'd1) $display("FAIL edge_tick: got %0d want 1", rom_address); else passed++;
        do_cycle(0, 0, 1, 1, 0);
        total++; if (rom_address !== 9'd2) $display("FAIL edge_btn: got %0d want 2", rom_address); else passed++;
    endtask

    task automatic test_reset_in_set();
        do_cycle(1, 0, 0, 0, 0);
        do_cycle(0, 0, 1, 0, 0);
        repeat (200) do_cycle(0, 0, 1, 1, 0);
        do_cycle(0, 0, 1, 0, 0);
        total++; if (rom_address !== 9'd200) $display("FAIL set_200: got %0d want 200", rom_address); else passed++;
        do_cycle(1, 0, 1, 0, 0);
        total++; if (rom_address !== 9'd0) $display("FAIL rst_set_addr: got %0d want 0", rom_address); else passed++;
        total++; if ({month, day, weekday} !== 12'h000) $display("FAIL rst_set_fields: got %h want 000", {month, day, weekday}); else passed++;
        total++; if (date_valid !== 1'b0) $display("FAIL rst_set_valid: got %b want 0", date_valid); else passed++;
        do_cycle(0, 1, 1, 0, 0);
        total++; if (rom_address !== 9'd1) $display("FAIL rst_set_state_run: got %0d want 1", rom_address); else passed++;
    endtask

    task automatic test_random();
        do_cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            do_cycle($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) < 2,
                     $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            total++; if (rom_address !== 9'(e_addr)) $display("FAIL rnd_addr[%0d]: got %0d want %0d", i, rom_address, e_addr); else passed++;
            total++; if ({month, day, weekday} !== e_fields) $display("FAIL rnd_fields[%0d]: got %h want %h", i, {month, day, weekday}, e_fields); else passed++;
            total++; if (date_valid !== e_valid) $display("FAIL rnd_valid[%0d]: got %b want %b", i, date_valid, e_valid); else passed++;
            total++; if (year_wrap !== e_wrap) $display("FAIL rnd_wrap[%0d]: got %b want %b", i, year_wrap, e_wrap); else passed++;
        end
        do_cycle(1, 0, 0, 0, 0);
        do_cycle(0, 0, 1, 0, 0);
        do_cycle(0, 0, 1, 0, 1);
        for (int i = 0; i < 40; i++) begin
            do_cycle(0, 1, i % 8 < 2, 0, 0);
            total++; if (rom_address !== 9'(e_addr)) $display("FAIL near_wrap_addr[%0d]: got %0d want %0d", i, rom_address, e_addr); else passed++;
            total++; if (year_wrap !== e_wrap) $display("FAIL near_wrap_pulse[%0d]: got %b want %b", i, year_wrap, e_wrap); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_run_ticks();
        test_year_wrap();
        test_set();
        test_mode_edge();
        test_reset_in_set();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
